// File: rtl/clock_multiplier.sv
// Phase-accumulator clock generator: gated_clk runs at M_eff*f/2^W, glitch-free stop/start (CLKMUL_ENABLE_SYNC_EN adds a 2-flop enable synchronizer).
// Output is a flop, one edge after the phase update; no backpressure, rate changes land on the next phase wrap.
module clock_multiplier #(
    parameter int MAX_MULTIPLIER = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [$clog2(MAX_MULTIPLIER)-1:0] multiplier,
    output logic                              gated_clk
);
    localparam int MW = $clog2(MAX_MULTIPLIER);
    localparam int W  = MW + 1;
    localparam logic [W-1:0] MAX_W = W'(MAX_MULTIPLIER);

    logic [W-1:0] phase_q, phase_d;
    logic [W-1:0] m_eff_q, m_eff_d;
    logic [W-1:0] m_dec;
    logic [W:0]   sum;
    logic         en_s;

`ifdef CLKMUL_ENABLE_SYNC_EN
    logic [1:0] en_sync_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q <= 2'b00;
        end else begin
            en_sync_q <= {en_sync_q[0], enable};
        end
    end

    assign en_s = en_sync_q[1];
`else
    assign en_s = enable;
`endif

    always_comb begin
        m_dec   = (multiplier == '0) ? MAX_W : {1'b0, multiplier};
        sum     = {1'b0, phase_q} + {1'b0, m_eff_q};
        phase_d = sum[W-1:0];
        m_eff_d = m_eff_q;
        if (en_s) begin
            if (sum[W]) begin
                m_eff_d = m_dec;
            end
        end else begin
            m_eff_d = m_dec;
            // Let a high phase run to completion, then park at zero.
            if (!phase_q[W-1] || !sum[W-1] || sum[W]) begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            m_eff_q <= W'(1);
        end else begin
            phase_q <= phase_d;
            m_eff_q <= m_eff_d;
        end
    end

    assign gated_clk = phase_q[W-1];

endmodule

// File: tb/tb_clock_multiplier.sv
// Bench for clock_multiplier: directed rate/stop/restart/reset scenarios plus random enable/multiplier traffic.
module tb_clock_multiplier;
    localparam int MAX  = 4;
    localparam int MW   = $clog2(MAX);
    localparam int W    = MW + 1;
    localparam int N    = 1 << W;
    localparam int HALF = N / 2;
`ifdef CLKMUL_ENABLE_SYNC_EN
    localparam int SYNC_LAT = 2;
    localparam logic [7:0] EXP_M2 = 8'b00011001;
`else
    localparam int SYNC_LAT = 0;
    localparam logic [7:0] EXP_M2 = 8'b01100110;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [MW-1:0] multiplier;
    logic          gated_clk;

    int checks   = 0;
    int failures = 0;

    // Reference: integer phase, effective rate and synchronizer stages.
    int m_p, m_m, m_s1, m_s2;

    clock_multiplier #(.MAX_MULTIPLIER(MAX)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .multiplier (multiplier),
        .gated_clk  (gated_clk)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_p  = 0;
        m_m  = 1;
        m_s1 = 0;
        m_s2 = 0;
    endtask

    task automatic model_edge();
        int en, dec, s;
        if (SYNC_LAT != 0) begin
            en   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(enable);
        end else begin
            en = int'(enable);
        end
        dec = (int'(multiplier) == 0) ? MAX : int'(multiplier);
        s   = m_p + m_m;
        if (en != 0) begin
            if (s >= N) m_m = dec;
            m_p = s % N;
        end else begin
            if (m_p >= HALF && s < N) m_p = s;
            else m_p = 0;
            m_m = dec;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic e;
        @(posedge clk_in);
        if (rst_n === 1'b1) model_edge();
        #1;
        e = (m_p >= HALF);
        check(tag, 32'(gated_clk), 32'(e));
    endtask

    task automatic wait_for(input logic level, input int bound, input string tag, output int n);
        n = 0;
        while (gated_clk !== level && n < bound) begin
            tick(tag);
            n++;
        end
        check({tag, "_reached"}, 32'(gated_clk), 32'(level));
    endtask

    task automatic high_len(input string tag, output int hi);
        hi = 1;
        for (int i = 0; i < 20 && gated_clk === 1'b1; i++) begin
            tick(tag);
            if (gated_clk === 1'b1) hi++;
        end
    endtask

    initial begin
        int r, n, hi;
        logic [7:0] v;

        model_reset();
        rst_n = 1'b1;
        enable = 1'b0;
        multiplier = '0;
        #1 rst_n = 1'b0;
        #1 check("reset_out", 32'(gated_clk), 32'd0);
        #10 rst_n = 1'b1;

        // Stopped edges load the new rate, then M=2 runs from P=0.
        multiplier = 2'd2;
        tick("stopped");
        tick("stopped");
        enable = 1'b1;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            tick("m2");
            v = {v[6:0], gated_clk};
        end
        check("m2_pattern", 32'(v), 32'(EXP_M2));

        r = 3; multiplier = r[MW-1:0];
        for (int i = 0; i < 16; i++) tick("m3");

        r = 4; multiplier = r[MW-1:0];
        for (int i = 0; i < 8; i++) tick("m4");
        v = '0;
        for (int i = 0; i < 4; i++) begin
            tick("m4");
            v = {v[6:0], gated_clk};
        end
        check("m4_toggle", 32'(v[3:0] == 4'b1010 || v[3:0] == 4'b0101), 32'd1);

        r = 5; multiplier = r[MW-1:0];
        for (int i = 0; i < 16; i++) tick("m5");

        // Drop enable at the start of a high phase: it must still last 4 edges.
        wait_for(1'b0, 20, "stop_wait_lo", n);
        wait_for(1'b1, 20, "stop_wait_hi", n);
        enable = 1'b0;
        high_len("stop_hi", hi);
        check("stop_high_len", 32'(hi), 32'd4);
        for (int i = 0; i < 6; i++) tick("stop_hold");

        enable = 1'b1;
        wait_for(1'b1, 20, "restart", n);
        check("restart_lat", 32'(n), 32'(4 + SYNC_LAT));

        // Rate change mid-high must not shorten the current phase.
        r = 4; multiplier = r[MW-1:0];
        high_len("midchg_hi", hi);
        check("midchg_high_len", 32'(hi), 32'd4);
        v = '0;
        for (int i = 0; i < 4; i++) begin
            tick("midchg_fast");
            v = {v[6:0], gated_clk};
        end
        check("midchg_toggle", 32'(v[3:0]), 32'(4'b1010));

        // Asynchronous reset during a high phase.
        wait_for(1'b1, 20, "arst_wait", n);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'(gated_clk), 32'd0);
        model_reset();
        r = 2; multiplier = r[MW-1:0];
        enable = 1'b1;
        #2 rst_n = 1'b1;
        wait_for(1'b1, 20, "post_rst", n);
        check("post_rst_lat", 32'(n), 32'(4 + SYNC_LAT));
        for (int i = 0; i < 16; i++) tick("post_rst_run");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 7);
                multiplier = r[MW-1:0];
            end
            tick("random");
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_rst", 32'(gated_clk), 32'd0);
                model_reset();
                #2 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_multiplier.md
# clock_multiplier

Digital rate-multiplied clock generator. It derives a square-wave output `gated_clk` from the fast reference `clk_in` through a phase accumulator, producing `multiplier` output cycles per base period of `2*MAX_MULTIPLIER` reference cycles. Output stop and start are glitch-free under `enable`. The block sits in the clock-management area and feeds downstream logic that needs a programmable, gateable slow clock.

## Interface
- `MAX_MULTIPLIER`, default 4: highest rate factor; must be a power of two ≥ 2. Accumulator width `W = $clog2(MAX_MULTIPLIER)+1`.
- `clk_in`  input  1  reference clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `enable`  input  1  run request; 1 = generate, 0 = stop output low (glitch-free).
- `multiplier`  input  `$clog2(MAX_MULTIPLIER)`  rate factor M; code 0 encodes `MAX_MULTIPLIER`. Wider writes truncate, so 4 → 0 → max rate and 5 → 1 when MAX=4.
- `gated_clk`  output  1  generated clock; equals the accumulator MSB and comes straight from a flop.

## Operation
- State: phase register `P[W-1:0]`; effective factor `M_eff` (W bits, range 1..MAX); `gated_clk = P[W-1]`.
- Decode: `M_dec = (multiplier==0) ? MAX_MULTIPLIER : multiplier`.
- Running (`en_s`=1): each edge `P <= (P + M_eff) mod 2^W`.
- Output frequency = `M_eff * f_clk_in / 2^W`. M=MAX toggles every cycle (f/2). M=1 gives f/8 at MAX=4.
- Non-power-of-two M gives a fractional rate with one-cycle jitter, e.g. M=3 → 3 periods per 8 cycles.
- `M_eff` reload: `M_eff <= M_dec` on any edge where the addition carries out of bit W-1 (phase wrap), and on every edge while stopped. A mid-period change of `multiplier` never truncates a high or low phase.
- Stopping (`en_s`=0):
  - If `P[W-1]`=1, keep advancing.
  - When the advanced value has MSB 0 (or wraps), force `P <= 0`.
  - If `P[W-1]`=0 already, force `P <= 0`.
  - The output therefore finishes its current high phase, then holds 0.
- Restart: from P=0 with a fresh `M_eff`. The first output high occurs after `2^(W-1)/M_eff` edges, rounded up.
- `en_s` is `enable` itself, or its synchronized copy (see Configuration).

## Timing
- Reset (`rst_n`=0, async): P=0, `M_eff`=1, `gated_clk`=0, synchronizer flops 0. Applies immediately, including mid-high phase. Release is sampled at the next `clk_in` rising edge.
- `gated_clk` changes only on `clk_in` rising edges, one flop delay after the edge. No combinational path from any input to `gated_clk`.
- Enable latency, without sync: the first edge sampling `enable`=1 advances P. With sync: 2 extra edges.
- Multiplier latency: applied at the next phase wrap while running, or at the next edge while stopped.
- Simultaneous wrap and `enable` fall: stop wins; P=0, and `M_eff` reloads.

## Configuration
- `CLKMUL_ENABLE_SYNC_EN` defined: `enable` passes through a 2-flop synchronizer clocked by `clk_in` and reset by `rst_n` to 0. `en_s` = second flop. Use when `enable` is asynchronous to `clk_in`.
- Not defined: `en_s = enable` directly. `enable` must meet setup/hold to `clk_in`.

## Test plan
- Reset, then `enable`=1, `multiplier`=2, 10 ns clk → `gated_clk` pattern 0,0,1,1 repeating, period 40 ns, 50 % duty.
- `multiplier`=3 → per 8 edges `gated_clk` = 0,0,1,0,1,1,0,1 after the next wrap (3 periods / 80 ns).
- `multiplier`=4 (truncates to 0) or `MAX_MULTIPLIER` → `gated_clk` toggles every edge (20 ns period). `multiplier`=5 behaves as 1 → 80 ns period, 4 high / 4 low.
- `enable` 1→0 while `gated_clk`=1 at M=1 → high phase completes its 4 cycles, then `gated_clk`=0 and P=0 held. `enable`=1 again → first rise 4 edges later.
- Change `multiplier` 1→4 mid-high phase → current high phase still lasts its full length; new rate starts after the wrap with no runt pulse.
- `rst_n`=0 asynchronously while `gated_clk`=1 → `gated_clk` drops to 0 without a clock edge. After release, restart at P=0 with M_eff=1 until the first wrap reloads M.
